// File: rtl/pmips_dmem_pkg.sv
// Shared constants and types for the PMIPS data-memory responder:
// MMIO address map, compare reset value and the address-decode select.
package pmips_dmem_pkg;

  localparam logic [7:0]  MMIO_PAGE  = 8'hFF;
  localparam logic [15:0] LED_ADDR   = 16'hFF00;
  localparam logic [15:0] SW_ADDR    = 16'hFF02;
  localparam logic [15:0] TIMER_ADDR = 16'hFF04;
  localparam logic [15:0] CMP_ADDR   = 16'hFF06;
  localparam logic [15:0] FLAG_ADDR  = 16'hFF08;

  localparam logic [15:0] CMP_RESET  = 16'hFFFF;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } sel_e;

endpackage

// File: rtl/pmips_dmem_timer.sv
// Free-running 16-bit compare timer with a sticky match flag.
// Only instantiated when PMIPS_DMEM_TIMER_EN is defined.
module pmips_dmem_timer
  import pmips_dmem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_timer_i,
  input  logic        wr_cmp_i,
  input  logic        wr_flag_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] timer_o,
  output logic [15:0] cmp_o,
  output logic        flag_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = wr_timer_i ? wdata_i : cnt_q + 16'd1;
    cmp_d  = wr_cmp_i ? wdata_i : cmp_q;
    flag_d = flag_q;
    if (wr_flag_i && wdata_i[0]) flag_d = 1'b0;
    // A match is checked last so it wins over a same-cycle clear.
    if (cnt_d == cmp_q) flag_d = 1'b1;
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= 16'h0000;
      cmp_q  <= CMP_RESET;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign timer_o = cnt_q;
  assign cmp_o   = cmp_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/pmips_dmem_responder.sv
// MEM-stage data port: word RAM plus an MMIO page (LED, synchronised switches,
// and an optional compare timer built when PMIPS_DMEM_TIMER_EN is defined).
module pmips_dmem_responder
  import pmips_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [7:0]  swin,
  output logic [7:0]  ledout,
  output logic        timerirq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [15:0]           mem_q [DEPTH];
  logic [15:0]           word_addr;
  logic [ADDR_WIDTH-1:0] ram_idx;
  sel_e                  sel;
  logic                  wr_en;
  logic                  mmio_wr;
  logic [7:0]            led_q, led_d;
  logic [7:0]            sync1_q, sync2_q;
  logic [15:0]           rdata;
  logic                  unused_addr_bit;

  // Byte address bit 0 is don't-care: all accesses are whole words.
  assign word_addr       = {dmemaddr[15:1], 1'b0};
  assign unused_addr_bit = dmemaddr[0];
  assign ram_idx         = dmemaddr[ADDR_WIDTH:1];
  assign wr_en           = dmemwrite & ~reset;

  always_comb begin
    if (dmemaddr[15:8] == MMIO_PAGE)                    sel = SEL_MMIO;
    else if ((dmemaddr >> (ADDR_WIDTH + 1)) == 16'h0000) sel = SEL_RAM;
    else                                                 sel = SEL_NONE;
  end

  assign mmio_wr = wr_en && (sel == SEL_MMIO);

`ifdef PMIPS_DMEM_TIMER_EN
  logic [15:0] timer_val, cmp_val;
  logic        flag_val;

  pmips_dmem_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .wr_timer_i (mmio_wr && (word_addr == TIMER_ADDR)),
    .wr_cmp_i   (mmio_wr && (word_addr == CMP_ADDR)),
    .wr_flag_i  (mmio_wr && (word_addr == FLAG_ADDR)),
    .wdata_i    (dmemwdata),
    .timer_o    (timer_val),
    .cmp_o      (cmp_val),
    .flag_o     (flag_val)
  );

  assign timerirq = flag_val;
`else
  assign timerirq = 1'b0;
`endif

  always_comb begin
    rdata = 16'h0000;
    if (dmemread) begin
      unique case (sel)
        SEL_RAM:  rdata = mem_q[ram_idx];
        SEL_MMIO: begin
          case (word_addr)
            LED_ADDR:   rdata = {8'h00, led_q};
            SW_ADDR:    rdata = {8'h00, sync2_q};
`ifdef PMIPS_DMEM_TIMER_EN
            TIMER_ADDR: rdata = timer_val;
            CMP_ADDR:   rdata = cmp_val;
            FLAG_ADDR:  rdata = {15'h0000, flag_val};
`endif
            default:    rdata = 16'h0000;
          endcase
        end
        default:  rdata = 16'h0000;
      endcase
    end
  end

  assign dmemrdata = rdata;

  // NOTE: the RAM array has no reset branch; contents survive reset and
  // the array maps onto plain memory without per-word reset logic.
  always_ff @(posedge clock) begin
    if (wr_en && (sel == SEL_RAM)) mem_q[ram_idx] <= dmemwdata;
  end

  always_comb begin
    led_d = led_q;
    if (mmio_wr && (word_addr == LED_ADDR)) led_d = dmemwdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= 8'h00;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      led_q   <= led_d;
      sync1_q <= swin;
      sync2_q <= sync1_q;
    end
  end

  assign ledout = led_q;

endmodule
